// File: rtl/shift_sequencer.sv
// shift_sequencer: control sequencer for an external parallel-in/serial-out
// shift register. Each transaction issues one load strobe, WIDTH shift
// strobes paced by a divided serial clock, then a one-cycle done pulse.
// All outputs are decoded from registered state only.
module shift_sequencer #(
  parameter int WIDTH  = 4,
  parameter int DIVIDE = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  output logic                         parallel_load,
  output logic                         peripheral_clk_edge,
  output logic                         sclk,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count
);

  localparam int CW = $clog2(WIDTH + 1);
  // The phase counter keeps at least one bit so DIVIDE=1 still has a legal vector.
  localparam int PW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(DIVIDE - 1);
  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    SHIFT_LOW  = 3'd2,
    SHIFT_HIGH = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [CW-1:0]   bit_count_q, bit_count_d;

  // Next-state, phase and strobe-count computation.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    phase_d     = phase_q;
    bit_count_d = bit_count_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d     = LOAD;
          phase_d     = '0;
          bit_count_d = '0;
        end
      end
      LOAD: begin
        state_d = SHIFT_LOW;
        phase_d = '0;
      end
      SHIFT_LOW: begin
        if (phase_q == LAST_PHASE) begin
          // The count advances on the same edge that raises sclk, so it
          // already includes the strobe issued in the first high cycle.
          state_d     = SHIFT_HIGH;
          phase_d     = '0;
          bit_count_d = bit_count_q + 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      SHIFT_HIGH: begin
        if (phase_q == LAST_PHASE) begin
          phase_d = '0;
          state_d = (bit_count_q == LAST_BIT) ? DONE : SHIFT_LOW;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        // Unused encodings recover straight to IDLE.
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    // Abort overrides everything outside IDLE, including the edge that would
    // enter DONE or raise the next strobe; the count is frozen where it was.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      phase_d     = '0;
      bit_count_d = bit_count_q;
    end
  end

  // State, phase and count registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      bit_count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_count_q <= bit_count_d;
    end
  end

  // Output decode from registered state only; nothing here sees start/abort.
  assign parallel_load       = (state_q == LOAD);
  assign peripheral_clk_edge = (state_q == SHIFT_HIGH) && (phase_q == '0);
  assign sclk                = (state_q == SHIFT_HIGH);
  assign busy                = (state_q != IDLE);
  assign done                = (state_q == DONE);
  assign bit_count           = bit_count_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: scoreboard bench for shift_sequencer. Two instances
// (WIDTH=4/DIVIDE=2 and WIDTH=1/DIVIDE=1) share the same start/abort/reset
// stimulus. A transaction-timeline reference model predicts each cycle's
// outputs; a separate monitor pops the predictions and compares.
module tb_shift_sequencer;

  localparam int W_A = 4;
  localparam int D_A = 2;
  localparam int W_B = 1;
  localparam int D_B = 1;

  logic clk;
  logic reset_n;
  logic start;
  logic abort;

  logic       pl_a, pce_a, sclk_a, busy_a, done_a;
  logic [2:0] bc_a;
  logic       pl_b, pce_b, sclk_b, busy_b, done_b;
  logic [0:0] bc_b;

  shift_sequencer #(.WIDTH(W_A), .DIVIDE(D_A)) dut_a (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start               (start),
    .abort               (abort),
    .parallel_load       (pl_a),
    .peripheral_clk_edge (pce_a),
    .sclk                (sclk_a),
    .busy                (busy_a),
    .done                (done_a),
    .bit_count           (bc_a)
  );

  shift_sequencer #(.WIDTH(W_B), .DIVIDE(D_B)) dut_b (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start               (start),
    .abort               (abort),
    .parallel_load       (pl_b),
    .peripheral_clk_edge (pce_b),
    .sclk                (sclk_b),
    .busy                (busy_b),
    .done                (done_b),
    .bit_count           (bc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output snapshot for one cycle.
  typedef struct packed {
    logic       pl;
    logic       pce;
    logic       sclk;
    logic       busy;
    logic       done;
    logic [7:0] bc;
  } snap_t;

  // Model state: whether a transaction is running, its start cycle, and the
  // strobe count last reported.
  typedef struct {
    bit run;
    int t0;
    int bc;
  } mstate_t;

  snap_t   q_a[$];
  snap_t   q_b[$];
  mstate_t s_a;
  mstate_t s_b;
  int      cyc;
  int      n_checks;
  int      n_errors;
  bit      mon_en;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Timeline model: start accepted in cycle t0 gives LOAD at t0+1, strobe k
  // at t0+2+D+2*D*k, sclk high in odd D-cycle phases, done at t0+2+2*D*W.
  function automatic snap_t model_out(input int w, input int d, input int c, input mstate_t s);
    snap_t e;
    int    rel;
    int    cnt;
    e    = '0;
    e.bc = 8'(s.bc);
    if (s.run) begin
      rel    = c - s.t0;
      e.busy = 1'b1;
      e.pl   = (rel == 1);
      e.done = (rel == 2 + 2 * d * w);
      if (rel >= 2 && rel <= 1 + 2 * d * w) begin
        e.sclk = (((rel - 2) / d) % 2) == 1;
        e.pce  = e.sclk && (((rel - 2) % d) == 0);
      end
      cnt = 0;
      for (int k = 0; k < w; k++)
        if (2 + d + 2 * d * k <= rel) cnt++;
      e.bc = 8'(cnt);
    end
    return e;
  endfunction

  function automatic mstate_t model_next(input int c, input mstate_t s, input snap_t e,
                                         input bit st, input bit ab);
    mstate_t n;
    n    = s;
    n.bc = int'(e.bc);
    if (s.run) begin
      if (ab || e.done) n.run = 1'b0;
    end else if (st && !ab) begin
      n.run = 1'b1;
      n.t0  = c;
      n.bc  = 0;
    end
    return n;
  endfunction

  // One cycle of stimulus: predict this cycle's outputs, then drive inputs
  // that the next rising edge will sample.
  task automatic run_cycle(input bit st, input bit ab, input bit rn);
    snap_t e_a;
    snap_t e_b;
    @(negedge clk);
    cyc++;
    e_a = model_out(W_A, D_A, cyc, s_a);
    e_b = model_out(W_B, D_B, cyc, s_b);
    q_a.push_back(e_a);
    q_b.push_back(e_b);
    start   = st;
    abort   = ab;
    reset_n = rn;
    if (rn) begin
      s_a = model_next(cyc, s_a, e_a, st, ab);
      s_b = model_next(cyc, s_b, e_b, st, ab);
    end else begin
      s_a = '{run: 1'b0, t0: 0, bc: 0};
      s_b = '{run: 1'b0, t0: 0, bc: 0};
    end
  endtask

  task automatic idle(input int n);
    repeat (n) run_cycle(1'b0, 1'b0, 1'b1);
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic async_reset(input string name);
    #3;
    reset_n = 1'b0;
    #1;
    check({name, "_a"}, {pl_a, pce_a, sclk_a, busy_a, done_a, 5'b0, bc_a}, 13'h0);
    check({name, "_b"}, {pl_b, pce_b, sclk_b, busy_b, done_b, 7'b0, bc_b}, 13'h0);
    s_a = '{run: 1'b0, t0: 0, bc: 0};
    s_b = '{run: 1'b0, t0: 0, bc: 0};
  endtask

  // Monitor: every cycle the DUTs present a full output set; compare it
  // against the oldest prediction.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (q_a.size() == 0 || q_b.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL scoreboard_underflow: got empty queue expected a prediction");
        end else begin
          check($sformatf("outputs_a c%0d", cyc),
                {pl_a, pce_a, sclk_a, busy_a, done_a, 5'b0, bc_a}, q_a.pop_front());
          check($sformatf("outputs_b c%0d", cyc),
                {pl_b, pce_b, sclk_b, busy_b, done_b, 7'b0, bc_b}, q_b.pop_front());
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    cyc      = 0;
    s_a      = '{run: 1'b0, t0: 0, bc: 0};
    s_b      = '{run: 1'b0, t0: 0, bc: 0};
    start    = 1'b0;
    abort    = 1'b0;
    reset_n  = 1'b1;

    // Power-on reset.
    async_reset("reset_state");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    mon_en = 1'b1;

    // Nominal single transaction.
    run_cycle(1'b1, 1'b0, 1'b1);
    idle(22);

    // Start held high through a whole transaction and beyond.
    repeat (25) run_cycle(1'b1, 1'b0, 1'b1);
    idle(20);

    // Abort in the ninth cycle after start.
    run_cycle(1'b1, 1'b0, 1'b1);
    idle(8);
    run_cycle(1'b0, 1'b1, 1'b1);
    idle(6);

    // Start and abort together in IDLE.
    run_cycle(1'b1, 1'b1, 1'b1);
    idle(4);

    // Abort coinciding with the last strobe, then with DONE entry.
    run_cycle(1'b1, 1'b0, 1'b1);
    idle(15);
    run_cycle(1'b0, 1'b1, 1'b1);
    idle(4);
    run_cycle(1'b1, 1'b0, 1'b1);
    idle(16);
    run_cycle(1'b0, 1'b1, 1'b1);
    idle(4);

    // Reset mid-transaction, then a start on the release edge.
    run_cycle(1'b1, 1'b0, 1'b1);
    idle(6);
    async_reset("mid_reset");
    run_cycle(1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b1);
    idle(22);

    // Randomized start/abort traffic.
    for (int i = 0; i < 3000; i++)
      run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, 1'b1);
    idle(24);

    #3;
    mon_en = 1'b0;
    check("scoreboard_drain", 13'(q_a.size() + q_b.size()), 13'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
